// File: rtl/conv_event_mp_accum.sv
// Event-driven conv-layer accumulator: pops spike events, fetches kernel weights and sums them
// into NPOS membrane potentials per output channel. Define MP_SAT_EN for saturating accumulation.
module conv_event_mp_accum #(
    parameter int unsigned K      = 3,
    parameter int unsigned NPOS   = 4,
    parameter int unsigned CH_I   = 256,
    parameter int unsigned CH_O   = 128,
    parameter int unsigned CI_W   = 8,
    parameter int unsigned CO_W   = 7,
    parameter int unsigned KPOS_W = 4,
    parameter int unsigned OPOS_W = 2,
    parameter int unsigned W_W    = 8,
    parameter int unsigned MP_W   = 16,
    parameter int unsigned ADDR_W = 19
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic                                       empty,
    output logic                                       r_en,
    input  logic [CI_W+CO_W+KPOS_W+OPOS_W:0]           evt_data,
    output logic [ADDR_W-1:0]                          w_addr,
    input  logic [W_W-1:0]                             w_data,
    output logic [NPOS*MP_W-1:0]                       mp_data,
    output logic [CO_W-1:0]                            mp_co,
    output logic                                       mp_valid,
    input  logic                                       mp_ready,
    output logic                                       drop
);

    localparam int unsigned EvtW   = CI_W + CO_W + KPOS_W + OPOS_W + 1;
    localparam int unsigned KSq    = K * K;
    localparam int unsigned KposLo = OPOS_W;
    localparam int unsigned CoLo   = OPOS_W + KPOS_W;
    localparam int unsigned CiLo   = OPOS_W + KPOS_W + CO_W;

    if (CH_O > (1 << CO_W)) begin : g_bad_co_w
        $error("CO_W too narrow for CH_O");
    end
    if (MP_W < W_W) begin : g_bad_mp_w
        $error("MP_W must be at least W_W");
    end

    typedef enum logic [1:0] {StIdle, StFetch, StAcc, StFlush} state_e;

    state_e                  state_q, state_d;
    logic [EvtW-1:0]         ev_q, ev_d;
    logic [CO_W-1:0]         cur_co_q, cur_co_d;
    logic                    dirty_q, dirty_d;
    logic                    pending_q, pending_d;
    logic [ADDR_W-1:0]       w_addr_q, w_addr_d;
    logic [MP_W-1:0]         mp_q [NPOS];
    logic [MP_W-1:0]         mp_d [NPOS];

    logic [OPOS_W-1:0] in_opos, ev_opos;
    logic [KPOS_W-1:0] in_kpos, ev_kpos;
    logic [CO_W-1:0]   in_co, ev_co;
    logic [CI_W-1:0]   in_ci, ev_ci;
    logic              ev_last;

    assign in_opos = evt_data[OPOS_W-1:0];
    assign in_kpos = evt_data[KposLo +: KPOS_W];
    assign in_co   = evt_data[CoLo +: CO_W];
    assign in_ci   = evt_data[CiLo +: CI_W];
    assign ev_opos = ev_q[OPOS_W-1:0];
    assign ev_kpos = ev_q[KposLo +: KPOS_W];
    assign ev_co   = ev_q[CoLo +: CO_W];
    assign ev_ci   = ev_q[CiLo +: CI_W];
    assign ev_last = ev_q[EvtW-1];

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CO_W-1:0]   co,
                                                   input logic [CI_W-1:0]   ci,
                                                   input logic [KPOS_W-1:0] kpos);
        return ADDR_W'((32'(co) * CH_I + 32'(ci)) * KSq + 32'(kpos));
    endfunction

    function automatic logic [MP_W-1:0] acc_add(input logic [MP_W-1:0] a,
                                                input logic [W_W-1:0]  w);
`ifdef MP_SAT_EN
        logic [MP_W:0] s;
        s = {a[MP_W-1], a} + (MP_W+1)'($signed(w));
        // Top two bits disagree only on overflow; the carry-out bit gives the direction
        if (s[MP_W] != s[MP_W-1]) begin
            return s[MP_W] ? {1'b1, {(MP_W-1){1'b0}}} : {1'b0, {(MP_W-1){1'b1}}};
        end
        return s[MP_W-1:0];
`else
        return a + MP_W'($signed(w));
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        ev_d      = ev_q;
        cur_co_d  = cur_co_q;
        dirty_d   = dirty_q;
        pending_d = pending_q;
        w_addr_d  = w_addr_q;
        mp_d      = mp_q;
        r_en      = 1'b0;
        drop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    r_en    = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                ev_d = evt_data;
                if (32'(in_opos) >= NPOS || 32'(in_kpos) >= KSq) begin
                    drop    = 1'b1;
                    state_d = StIdle;
                end else if (dirty_q && in_co != cur_co_q) begin
                    pending_d = 1'b1;
                    state_d   = StFlush;
                end else begin
                    cur_co_d = in_co;
                    w_addr_d = addr_of(in_co, in_ci, in_kpos);
                    state_d  = StAcc;
                end
            end
            StAcc: begin
                mp_d[ev_opos] = acc_add(mp_q[ev_opos], w_data);
                dirty_d       = 1'b1;
                state_d       = ev_last ? StFlush : StIdle;
            end
            StFlush: begin
                if (mp_ready) begin
                    for (int p = 0; p < NPOS; p++) mp_d[p] = '0;
                    dirty_d = 1'b0;
                    // A channel change parked the event; resume it straight into ACC
                    if (pending_q) begin
                        pending_d = 1'b0;
                        cur_co_d  = ev_co;
                        w_addr_d  = addr_of(ev_co, ev_ci, ev_kpos);
                        state_d   = StAcc;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            ev_q      <= '0;
            cur_co_q  <= '0;
            dirty_q   <= 1'b0;
            pending_q <= 1'b0;
            w_addr_q  <= '0;
            for (int p = 0; p < NPOS; p++) mp_q[p] <= '0;
        end else begin
            state_q   <= state_d;
            ev_q      <= ev_d;
            cur_co_q  <= cur_co_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
            w_addr_q  <= w_addr_d;
            mp_q      <= mp_d;
        end
    end

    always_comb begin
        mp_data = '0;
        for (int p = 0; p < NPOS; p++) mp_data[p*MP_W +: MP_W] = mp_q[p];
    end

    assign w_addr   = w_addr_d;
    assign mp_co    = cur_co_q;
    assign mp_valid = (state_q == StFlush);

endmodule

// File: tb/tb_conv_event_mp_accum.sv
// Bench for conv_event_mp_accum: FIFO and weight RAM models plus an event-level reference model
// that predicts every flushed MP vector, drop count and idle accumulator state.
module tb_conv_event_mp_accum;

    localparam int unsigned K      = 3;
    localparam int unsigned NPOS   = 4;
    localparam int unsigned CH_I   = 256;
    localparam int unsigned CI_W   = 8;
    localparam int unsigned CO_W   = 7;
    localparam int unsigned KPOS_W = 4;
    localparam int unsigned OPOS_W = 2;
    localparam int unsigned W_W    = 8;
    localparam int unsigned MP_W   = 16;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned EW     = CI_W + CO_W + KPOS_W + OPOS_W + 1;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   empty = 1'b1;
    logic                   r_en;
    logic [EW-1:0]          evt_data = '0;
    logic [ADDR_W-1:0]      w_addr;
    logic [W_W-1:0]         w_data = '0;
    logic [NPOS*MP_W-1:0]   mp_data;
    logic [CO_W-1:0]        mp_co;
    logic                   mp_valid;
    logic                   mp_ready = 1'b1;
    logic                   drop;

    always #5 clk = ~clk;

    conv_event_mp_accum dut (
        .clk      (clk),
        .rstn     (rstn),
        .empty    (empty),
        .r_en     (r_en),
        .evt_data (evt_data),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .mp_data  (mp_data),
        .mp_co    (mp_co),
        .mp_valid (mp_valid),
        .mp_ready (mp_ready),
        .drop     (drop)
    );

    typedef struct {
        longint co;
        longint mp [NPOS];
    } flush_t;

    flush_t         exp_q [$];
    flush_t         obs_q [$];
    logic [EW-1:0]  fifo_q [$];
    logic [W_W-1:0] wmem [int];
    int             total = 0;
    int             bad = 0;
    int             drop_seen = 0;
    int             drop_exp = 0;
    int             ren_bad = 0;
    longint         m_mp [NPOS];
    longint         m_cur = 0;
    bit             m_dirty = 1'b0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W_W-1:0] wfun(input int addr);
        if (wmem.exists(addr)) return wmem[addr];
        return W_W'(addr * 37 + (addr >> 3));
    endfunction

    function automatic longint mp_at(input int p);
        return longint'($signed(mp_data[p*MP_W +: MP_W]));
    endfunction

    // Reference arithmetic on plain integers
    function automatic longint m_add(input longint a, input longint w);
        longint s;
        longint lim;
        lim = longint'(1) << (MP_W - 1);
        s = a + w;
`ifdef MP_SAT_EN
        if (s > lim - 1) s = lim - 1;
        if (s < -lim) s = -lim;
`else
        s = (s + lim) % (2 * lim);
        if (s < 0) s += 2 * lim;
        s -= lim;
`endif
        return s;
    endfunction

    task automatic m_flush();
        flush_t f;
        f.co = m_cur;
        f.mp = m_mp;
        exp_q.push_back(f);
        for (int p = 0; p < NPOS; p++) m_mp[p] = 0;
        m_dirty = 1'b0;
    endtask

    task automatic push_ev(input bit last, input int ci, input int co, input int kpos,
                           input int opos);
        int addr;
        fifo_q.push_back({last, CI_W'(ci), CO_W'(co), KPOS_W'(kpos), OPOS_W'(opos)});
        if (opos >= NPOS || kpos >= K * K) begin
            drop_exp++;
            return;
        end
        if (m_dirty && co != m_cur) m_flush();
        m_cur = co;
        addr = (co * CH_I + ci) * K * K + kpos;
        m_mp[opos] = m_add(m_mp[opos], longint'($signed(wfun(addr))));
        m_dirty = 1'b1;
        if (last) m_flush();
    endtask

    // FIFO pops on r_en (data next cycle); weight RAM has one cycle of latency
    always @(posedge clk) begin
        w_data <= wfun(int'(w_addr));
        if (r_en) begin
            if (fifo_q.size() == 0) ren_bad++;
            else evt_data <= fifo_q.pop_front();
        end
    end

    always @(negedge clk) begin
        flush_t o;
        flush_t e;
        empty = (fifo_q.size() == 0);
        if (drop) drop_seen++;
        if (r_en && mp_valid) ren_bad++;
        if (mp_valid && mp_ready) begin
            o.co = longint'(mp_co);
            for (int p = 0; p < NPOS; p++) o.mp[p] = mp_at(p);
            obs_q.push_back(o);
            check_eq("flush_expected", longint'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("flush_co", o.co, e.co);
                for (int p = 0; p < NPOS; p++)
                    check_eq($sformatf("flush_mp%0d", p), o.mp[p], e.mp[p]);
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        while (n < 4000 && quiet < 4) begin
            @(negedge clk);
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !mp_valid && !r_en) quiet++;
            else quiet = 0;
            n++;
        end
        check_eq({tag, "_drain"}, longint'(quiet >= 4), 1);
        for (int p = 0; p < NPOS; p++) check_eq($sformatf("%s_mp%0d", tag, p), mp_at(p), m_mp[p]);
        check_eq({tag, "_co"}, longint'(mp_co), m_cur);
        check_eq({tag, "_drops"}, drop_seen, drop_exp);
        check_eq({tag, "_ren_bad"}, ren_bad, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NPOS*MP_W-1:0] snap;
        int                   n;
        int                   drops0;
        for (int p = 0; p < NPOS; p++) m_mp[p] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ren", r_en, 0);
        check_eq("rst_waddr", w_addr, 0);
        check_eq("rst_mp", mp_data, 0);
        check_eq("rst_co", mp_co, 0);
        check_eq("rst_valid", mp_valid, 0);
        check_eq("rst_drop", drop, 0);
        tick();
        rstn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_eq("idle_ren", r_en, 0);
            check_eq("idle_valid", mp_valid, 0);
        end
        check_eq("idle_waddr", w_addr, 0);

        // Three events into co=5, the last one flushes
        wmem[11520] = 8'd12;
        wmem[11533] = 8'hE5;
        wmem[11522] = 8'd31;
        obs_q.delete();
        push_ev(0, 0, 5, 0, 1);
        wait_idle("t1a");
        check_eq("t1_addr0", w_addr, 11520);
        push_ev(0, 1, 5, 4, 1);
        wait_idle("t1b");
        check_eq("t1_addr1", w_addr, 11533);
        check_eq("t1_mp1_pre", mp_at(1), -15);
        push_ev(1, 0, 5, 2, 3);
        wait_idle("t1c");
        check_eq("t1_addr2", w_addr, 11522);
        check_eq("t1_nflush", obs_q.size(), 1);
        if (obs_q.size() >= 1) begin
            check_eq("t1_co", obs_q[0].co, 5);
            check_eq("t1_mp1", obs_q[0].mp[1], -15);
            check_eq("t1_mp3", obs_q[0].mp[3], 31);
        end

        // Channel change on a last event gives two ordered flushes
        wmem[11538] = 8'd44;
        wmem[13825] = 8'hFC;
        obs_q.delete();
        push_ev(0, 2, 5, 0, 0);
        push_ev(1, 0, 6, 1, 2);
        wait_idle("t2");
        check_eq("t2_nflush", obs_q.size(), 2);
        if (obs_q.size() >= 2) begin
            check_eq("t2_co0", obs_q[0].co, 5);
            check_eq("t2_f0_mp0", obs_q[0].mp[0], 44);
            check_eq("t2_f0_mp2", obs_q[0].mp[2], 0);
            check_eq("t2_co1", obs_q[1].co, 6);
            check_eq("t2_f1_mp2", obs_q[1].mp[2], -4);
            check_eq("t2_f1_mp0", obs_q[1].mp[0], 0);
        end
        check_eq("t2_addr", w_addr, 13825);

        // Backpressure: flush held 10 cycles with another event waiting in the FIFO
        wmem[16128] = 8'd9;
        tick();
        mp_ready = 1'b0;
        push_ev(1, 0, 7, 0, 0);
        n = 0;
        while (n < 50 && !mp_valid) begin
            @(negedge clk);
            n++;
        end
        check_eq("t3_valid", mp_valid, 1);
        push_ev(0, 3, 7, 0, 1);
        snap = mp_data;
        check_eq("t3_snap_mp0", mp_at(0), 9);
        repeat (10) begin
            @(negedge clk);
            check_eq("t3_stable", longint'(mp_data == snap), 1);
            check_eq("t3_valid_hold", mp_valid, 1);
            check_eq("t3_no_ren", r_en, 0);
            check_eq("t3_fifo", fifo_q.size(), 1);
        end
        tick();
        mp_ready = 1'b1;
        wait_idle("t3");
        push_ev(1, 1, 7, 0, 1);
        wait_idle("t3b");

        // Out-of-range kernel positions are dropped without touching the MPs
        drops0 = drop_seen;
        push_ev(0, 0, 3, 0, 0);
        wait_idle("t4a");
        push_ev(1, 0, 3, 9, 1);
        push_ev(0, 0, 3, 15, 2);
        wait_idle("t4b");
        check_eq("t4_drops", drop_seen - drops0, 2);
        push_ev(1, 1, 3, 1, 1);
        wait_idle("t4c");

        // Long run into one accumulator
        wmem[4608] = 8'd127;
        obs_q.delete();
        for (int i = 0; i < 300; i++) push_ev(i == 299, 0, 2, 0, 0);
        wait_idle("t5");
        check_eq("t5_nflush", obs_q.size(), 1);
        if (obs_q.size() >= 1) begin
`ifdef MP_SAT_EN
            check_eq("t5_sat", obs_q[0].mp[0], 32767);
`else
            check_eq("t5_wrap", obs_q[0].mp[0], -27436);
`endif
        end

        // Random traffic with random backpressure
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(2)) begin
                tick();
                mp_ready = ($urandom_range(3) != 0);
            end
            push_ev($urandom_range(7) == 0, int'($urandom_range(255)), int'($urandom_range(3)),
                    int'($urandom_range(11)), int'($urandom_range(3)));
        end
        push_ev(1, 0, 1, 0, 0);
        tick();
        mp_ready = 1'b1;
        wait_idle("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
